matmul_result_serializer: RTL and testbench
===========================================

# matmul_result_serializer

Downstream stage of `matrix_multiplier`. It captures the registered result matrix (the `c_o` array and its `valid_o` pulse) in one cycle, then streams it element by element in row-major order over a valid/ready interface to the writeback/DMA logic. Because the multiplier has no backpressure, a capture-overrun detector with a sticky flag and a saturating drop counter is included.

## Interface
- `C_DATA_WIDTH`, 19, element width; equals the multiplier's `(2*DATA_WIDTH)+$clog2(A_COLUMNS_B_ROWS)`.
- `C_ROWS`, 8, result rows (the multiplier's `A_ROWS`).
- `C_COLUMNS`, 5, result columns (the multiplier's `B_COLUMNS`).
- `DROP_CNT_WIDTH`, 8, width of the dropped-matrix counter.
- `clk_i` in 1: the single clock.
- `reset_ni` in 1: reset, synchronous, active-low.
- `valid_i` in 1: result-valid pulse from the multiplier.
- `c_i` in `[C_DATA_WIDTH-1:0] x C_ROWS*C_COLUMNS`: result array, row-major.
- `ready_o` out 1: the block can capture this cycle (status only; the multiplier ignores it).
- `m_valid_o` out 1: stream element valid.
- `m_ready_i` in 1: downstream accepts.
- `m_data_o` out `C_DATA_WIDTH`: current element.
- `m_row_o` out `$clog2(C_ROWS)`: row index of `m_data_o`.
- `m_col_o` out `$clog2(C_COLUMNS)`: column index of `m_data_o`.
- `m_row_last_o` out 1: element is the last in its row.
- `m_last_o` out 1: element is the last of the matrix.
- `overflow_o` out 1: sticky; set when a matrix was dropped.
- `drop_cnt_o` out `DROP_CNT_WIDTH`: number of dropped matrices, saturating.

## Operation
- **States.** IDLE and STREAM (enum in package).
- **IDLE.**
  - `ready_o`=1.
  - `valid_i`=1: copy all of `c_i` into the buffer, set element index to (0,0), go to STREAM.
- **STREAM.**
  - `m_valid_o`=1. `m_data_o`=buf[row*C_COLUMNS+col], driven from registers only, with no combinational path from `c_i`.
  - A handshake (`m_valid_o && m_ready_i`) advances the index: col++; at col=C_COLUMNS-1, col←0 and row++.
  - `m_row_last_o`=(col==C_COLUMNS-1). `m_last_o`=`m_row_last_o` && (row==C_ROWS-1).
- **Last handshake** (`m_last_o` && `m_ready_i`):
  - If `valid_i` is high in the same cycle, capture the new matrix, reset the index to (0,0) and stay in STREAM. This gives a back-to-back stream with no bubble.
  - Otherwise go to IDLE.
- **`ready_o`** = IDLE || (STREAM && `m_last_o` && `m_ready_i`). It is combinational from state and `m_ready_i`.
- **Overrun.** `valid_i`=1 while `ready_o`=0:
  - The incoming matrix is discarded; buffer, index and stream are untouched.
  - `overflow_o`←1.
  - `drop_cnt_o` increments and saturates at all-ones.
- **Stalls.** While `m_valid_o` && !`m_ready_i`, `m_data_o`, `m_row_o`, `m_col_o` and both last flags are held stable. `m_valid_o` never drops before its handshake.
- **Status clearing.** `overflow_o` and `drop_cnt_o` clear only on reset.
- **Width.** No arithmetic is applied to data; elements pass bit-exact.

## Timing
- **Reset** (`reset_ni`=0 at a rising edge; takes effect at that edge):
  - state=IDLE.
  - `m_valid_o`=0, `m_data_o`=0, `m_row_o`=0, `m_col_o`=0, `m_row_last_o`=0, `m_last_o`=0.
  - `overflow_o`=0, `drop_cnt_o`=0.
  - `ready_o`=1 from the first cycle after reset.
  - Buffer contents need no reset.
  - Reset mid-stream aborts the matrix immediately: no further elements, no `m_last_o`.
- **Latency.** A `valid_i` sampled at edge N gives `m_valid_o`=1 with element (0,0) after edge N, i.e. in cycle N+1.
- **Throughput.** With `m_ready_i` held high, a matrix takes exactly C_ROWS*C_COLUMNS cycles (40 at defaults). Back-to-back matrices stream without a gap.
- **Minimum pulse spacing.** The multiplier must space `valid_i` pulses at least C_ROWS*C_COLUMNS cycles apart, aligned to the last handshake; any closer pulse is an overrun.

## Structure
- **Package `matmul_pkg`:**
  - serializer state enum (`SER_IDLE`, `SER_STREAM`);
  - localparams for the index widths, using `$clog2` with a minimum of 1;
  - a helper function for the row-major flat index.
- **Sub-module `sat_counter`:** parameterised width, with increment enable and a synchronous active-low clear. It implements `drop_cnt_o` and is reusable by the neighbouring coverage and monitor blocks.
- **Top-level RTL:** the buffer, index counters and FSM live here.

## Test plan
- **Single matrix, no backpressure.**
  - Stimulus: after reset, `c_i`[k]=k+1, one `valid_i` pulse, `m_ready_i`=1.
  - Response: 40 consecutive beats with data 1..40.
  - `m_row_last_o` on beats 5, 10, …, 40; `m_last_o` only on beat 40.
  - `ready_o` low from cycle 2 until the final beat.
- **Backpressure.**
  - Stimulus: `m_ready_i` toggles 1,0,0,1,… .
  - Response: data, indices and flags are held during low cycles; no element is duplicated or lost; 40 handshakes in total.
- **Back-to-back.**
  - Stimulus: a second `valid_i` (`c_i`[k]=100+k) coincident with the first matrix's last handshake.
  - Response: the beat after 40 is 100; no idle cycle; overflow stays 0.
- **Overrun.**
  - Stimulus: `valid_i` at beat 10 of a stream.
  - Response: the stream continues with the original data 11..40; `overflow_o`=1; `drop_cnt_o`=1.
- **Saturation.**
  - Stimulus: force 300 overrun pulses with `DROP_CNT_WIDTH`=8.
  - Response: `drop_cnt_o`=255 and it stays there.
- **Reset mid-stream.**
  - Stimulus: `reset_ni` low for one edge at beat 20.
  - Response: next cycle `m_valid_o`=0, all outputs 0, `ready_o`=1; a new `valid_i` restarts at element (0,0).

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiplier result path.
// Holds the serializer state encoding, default geometry, index-width
// helpers and the row-major flattening function used by the serializer
// and its neighbouring monitor blocks.
package matmul_pkg;

  typedef enum logic [0:0] {
    SER_IDLE   = 1'b0,
    SER_STREAM = 1'b1
  } ser_state_e;

  localparam int unsigned C_ROWS_DEFAULT    = 8;
  localparam int unsigned C_COLUMNS_DEFAULT = 5;

  // Index width for a count of n items; never narrower than one bit so a
  // degenerate 1-row or 1-column matrix still has a legal port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ROW_IDX_W = idx_width(C_ROWS_DEFAULT);
  localparam int unsigned COL_IDX_W = idx_width(C_COLUMNS_DEFAULT);

  // Row-major position of element (row, col) in a matrix with ncols columns.
  function automatic int unsigned flat_index(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned ncols);
    return row * ncols + col;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable and synchronous active-low
// clear. Sticks at all-ones once reached.
// Ports:
//   clk_i  - clock
//   clr_ni - synchronous clear, active low
//   inc_i  - increment request for this cycle
//   cnt_o  - current count
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + WIDTH'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the values from before the edge.
  always_ff @(posedge clk_i) begin
    if (!clr_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/matmul_result_serializer.sv
// Captures the multiplier's result matrix in one cycle and streams it
// element by element, row-major, over a valid/ready interface. A matrix
// arriving while the block cannot capture is dropped and recorded in a
// sticky overflow flag and a saturating drop counter.
// Ports:
//   clk_i, reset_ni     - clock, synchronous active-low reset
//   valid_i, c_i        - result pulse and result array from the multiplier
//   ready_o             - capture possible this cycle (status only)
//   m_valid_o/m_ready_i - stream handshake
//   m_data_o            - current element
//   m_row_o, m_col_o    - position of the current element
//   m_row_last_o        - last element of its row
//   m_last_o            - last element of the matrix
//   overflow_o          - sticky: a matrix was dropped
//   drop_cnt_o          - saturating count of dropped matrices
module matmul_result_serializer
  import matmul_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH   = 19,
  parameter int unsigned C_ROWS         = C_ROWS_DEFAULT,
  parameter int unsigned C_COLUMNS      = C_COLUMNS_DEFAULT,
  parameter int unsigned DROP_CNT_WIDTH = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic                              valid_i,
  input  logic [C_DATA_WIDTH-1:0]           c_i [C_ROWS*C_COLUMNS],
  output logic                              ready_o,
  output logic                              m_valid_o,
  input  logic                              m_ready_i,
  output logic [C_DATA_WIDTH-1:0]           m_data_o,
  output logic [idx_width(C_ROWS)-1:0]      m_row_o,
  output logic [idx_width(C_COLUMNS)-1:0]   m_col_o,
  output logic                              m_row_last_o,
  output logic                              m_last_o,
  output logic                              overflow_o,
  output logic [DROP_CNT_WIDTH-1:0]         drop_cnt_o
);

  localparam int unsigned N     = C_ROWS * C_COLUMNS;
  localparam int unsigned ROW_W = idx_width(C_ROWS);
  localparam int unsigned COL_W = idx_width(C_COLUMNS);
  localparam int unsigned IDX_W = idx_width(N);
  localparam logic [ROW_W-1:0] ROW_END = ROW_W'(C_ROWS - 1);
  localparam logic [COL_W-1:0] COL_END = COL_W'(C_COLUMNS - 1);

  ser_state_e        state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              overflow_q, overflow_d;
  logic [C_DATA_WIDTH-1:0] buf_q [N];

  logic             is_stream, row_end, mat_end, handshake;
  logic             capture, overrun;
  logic [IDX_W-1:0] flat_idx;

  assign is_stream = (state_q == SER_STREAM);
  assign row_end   = (col_q == COL_END);
  assign mat_end   = row_end && (row_q == ROW_END);
  assign handshake = is_stream && m_ready_i;

  // Capture is possible when idle, or when the final element leaves in this
  // very cycle, which lets a new matrix follow with no bubble.
  assign ready_o = !is_stream || (mat_end && handshake);
  assign capture = valid_i && ready_o;
  assign overrun = valid_i && !ready_o;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    overflow_d = overflow_q || overrun;
    if (capture) begin
      state_d = SER_STREAM;
      row_d   = '0;
      col_d   = '0;
    end else if (handshake) begin
      if (mat_end) begin
        state_d = SER_IDLE;
        row_d   = '0;
        col_d   = '0;
      end else if (row_end) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= SER_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the matrix buffer has no reset; its contents are only observed
  // after a capture has overwritten every entry, and leaving it out keeps
  // the storage a plain register file.
  always_ff @(posedge clk_i) begin
    if (capture) buf_q <= c_i;
  end

  sat_counter #(
    .WIDTH (DROP_CNT_WIDTH)
  ) u_drop_cnt (
    .clk_i  (clk_i),
    .clr_ni (reset_ni),
    .inc_i  (overrun),
    .cnt_o  (drop_cnt_o)
  );

  assign flat_idx = IDX_W'(flat_index(32'(row_q), 32'(col_q), C_COLUMNS));

  // Stream outputs come from the buffer and index registers only; they are
  // forced to zero outside STREAM so reset and idle present a clean bus.
  assign m_valid_o    = is_stream;
  assign m_data_o     = is_stream ? buf_q[flat_idx] : '0;
  assign m_row_o      = row_q;
  assign m_col_o      = col_q;
  assign m_row_last_o = is_stream && row_end;
  assign m_last_o     = is_stream && mat_end;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_matmul_result_serializer.sv
// Scoreboard bench for matmul_result_serializer. The stimulus process keeps
// a beat-count model of the stream, predicts acceptance or drop of each
// valid_i pulse and queues the expected beats; the monitor compares every
// handshake and every status output at the falling edge.
module tb_matmul_result_serializer;
  import matmul_pkg::*;

  localparam int DW    = 19;
  localparam int ROWS  = 8;
  localparam int COLS  = 5;
  localparam int N     = ROWS * COLS;
  localparam int DCW   = 8;
  localparam int DMAX  = (1 << DCW) - 1;

  typedef struct {
    logic [DW-1:0] data;
    int            row;
    int            col;
    bit            row_last;
    bit            last;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 reset_ni = 1'b0;
  logic                 valid_i = 1'b0;
  logic [DW-1:0]        c_i [N];
  logic                 ready_o;
  logic                 m_valid_o;
  logic                 m_ready_i = 1'b0;
  logic [DW-1:0]        m_data_o;
  logic [ROW_IDX_W-1:0] m_row_o;
  logic [COL_IDX_W-1:0] m_col_o;
  logic                 m_row_last_o;
  logic                 m_last_o;
  logic                 overflow_o;
  logic [DCW-1:0]       drop_cnt_o;

  matmul_result_serializer #(
    .C_DATA_WIDTH   (DW),
    .C_ROWS         (ROWS),
    .C_COLUMNS      (COLS),
    .DROP_CNT_WIDTH (DCW)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .valid_i      (valid_i),
    .c_i          (c_i),
    .ready_o      (ready_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .m_row_o      (m_row_o),
    .m_col_o      (m_col_o),
    .m_row_last_o (m_row_last_o),
    .m_last_o     (m_last_o),
    .overflow_o   (overflow_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model state (written by stimulus, read by the monitor).
  beat_t         sb [$];
  logic [DW-1:0] nxt [N];
  int            left      = 0;   // beats of the current matrix not yet taken
  bit            exp_ready = 1'b1;
  bit            exp_ovf   = 1'b0;
  int            exp_drop  = 0;
  int            n_timeouts = 0;
  bit            done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model advances with the clock edge.
  task automatic step(input bit v, input bit r);
    bit acc, hs;
    valid_i   = v;
    m_ready_i = r;
    if (v) c_i = nxt;
    hs        = (left > 0) && r;
    exp_ready = (left == 0) || ((left == 1) && r);
    acc       = v && exp_ready;
    if (acc) begin
      for (int k = 0; k < N; k++) begin
        beat_t b;
        b.data     = nxt[k];
        b.row      = k / COLS;
        b.col      = k % COLS;
        b.row_last = ((k % COLS) == COLS - 1);
        b.last     = (k == N - 1);
        sb.push_back(b);
      end
    end
    @(posedge clk);
    if (v && !acc) begin
      exp_ovf = 1'b1;
      if (exp_drop < DMAX) exp_drop++;
    end
    if (acc)     left = N;
    else if (hs) left = left - 1;
    #1;
  endtask

  task automatic do_reset();
    reset_ni  = 1'b0;
    valid_i   = 1'b0;
    m_ready_i = 1'b0;
    @(posedge clk);
    sb.delete();
    left      = 0;
    exp_ovf   = 1'b0;
    exp_drop  = 0;
    exp_ready = 1'b1;
    #1;
    reset_ni  = 1'b1;
  endtask

  task automatic fill_seq(input int base);
    for (int k = 0; k < N; k++) nxt[k] = DW'(base + k);
  endtask

  task automatic drain();
    int guard = 0;
    while (left > 0 && guard < 1000) begin
      step(1'b0, 1'b1);
      guard++;
    end
    if (left > 0) n_timeouts++;
  endtask

  task automatic run_until(input int target);
    int guard = 0;
    while (left > target && guard < 1000) begin
      step(1'b0, 1'b1);
      guard++;
    end
    if (left != target) n_timeouts++;
  endtask

  // Monitor: compares outputs and pops the scoreboard on each handshake.
  bit            rst_prev = 1'b1;
  bit            p_stall  = 1'b0;
  logic [DW-1:0] p_data;
  logic [31:0]   p_row, p_col;
  bit            p_rl, p_last;

  always @(negedge clk) begin
    if (!reset_ni) begin
      rst_prev = 1'b1;
      p_stall  = 1'b0;
    end else begin
      check("ready_o", 32'(ready_o), 32'(exp_ready));
      check("m_valid_o", 32'(m_valid_o), 32'(left != 0));
      check("overflow_o", 32'(overflow_o), 32'(exp_ovf));
      check("drop_cnt_o", 32'(drop_cnt_o), 32'(exp_drop));
      if (rst_prev) begin
        check("rst_m_data", 32'(m_data_o), 0);
        check("rst_m_row", 32'(m_row_o), 0);
        check("rst_m_col", 32'(m_col_o), 0);
        check("rst_row_last", 32'(m_row_last_o), 0);
        check("rst_last", 32'(m_last_o), 0);
      end
      if (p_stall) begin
        check("stall_data", 32'(m_data_o), 32'(p_data));
        check("stall_row", 32'(m_row_o), p_row);
        check("stall_col", 32'(m_col_o), p_col);
        check("stall_row_last", 32'(m_row_last_o), 32'(p_rl));
        check("stall_last", 32'(m_last_o), 32'(p_last));
        check("stall_valid", 32'(m_valid_o), 1);
      end
      if (m_valid_o && m_ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'(m_data_o), 32'hFFFF_FFFF);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("beat_data", 32'(m_data_o), 32'(e.data));
          check("beat_row", 32'(m_row_o), 32'(e.row));
          check("beat_col", 32'(m_col_o), 32'(e.col));
          check("beat_row_last", 32'(m_row_last_o), 32'(e.row_last));
          check("beat_last", 32'(m_last_o), 32'(e.last));
        end
      end
      p_stall  = m_valid_o && !m_ready_i;
      p_data   = m_data_o;
      p_row    = 32'(m_row_o);
      p_col    = 32'(m_col_o);
      p_rl     = m_row_last_o;
      p_last   = m_last_o;
      rst_prev = 1'b0;
    end
    if (done) begin
      check("scoreboard_empty", 32'(sb.size()), 0);
      check("wait_timeouts", 32'(n_timeouts), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    fill_seq(0);
    c_i = nxt;
    do_reset();
    step(1'b0, 1'b0);

    // Single matrix, no backpressure: data 1..40.
    fill_seq(1);
    step(1'b1, 1'b1);
    drain();
    step(1'b0, 1'b1);

    // Backpressure with ready pattern 1,0,0,...
    fill_seq(1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 400 && left > 0; i++) step(1'b0, (i % 3) == 0);
    drain();

    // Back-to-back: second matrix on the first one's last handshake.
    fill_seq(1);
    step(1'b1, 1'b1);
    run_until(1);
    fill_seq(100);
    step(1'b1, 1'b1);
    drain();

    // Overrun at beat 10: stream keeps its original data.
    fill_seq(1);
    step(1'b1, 1'b1);
    run_until(N - 9);
    fill_seq(500);
    step(1'b1, 1'b1);
    drain();

    // Saturation: 300 overruns while the stream is stalled.
    do_reset();
    fill_seq(7);
    step(1'b1, 1'b1);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0);
    drain();

    // Reset mid-stream at beat 20, then restart from (0,0).
    fill_seq(1);
    step(1'b1, 1'b1);
    run_until(N - 20);
    do_reset();
    step(1'b0, 1'b0);
    fill_seq(1);
    step(1'b1, 1'b1);
    drain();

    // Randomized traffic with random data, valid pulses and backpressure.
    for (int i = 0; i < 3000; i++) begin
      bit v, r;
      v = ($urandom_range(0, 29) == 0);
      r = ($urandom_range(0, 3) != 0);
      if (v) for (int k = 0; k < N; k++) nxt[k] = DW'($urandom);
      step(v, r);
    end
    drain();
    step(1'b0, 1'b0);

    done = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL monitor_end: got 0 expected 1");
    $fatal(1);
  end

endmodule
